mdu_hilo: RTL and testbench

- Multiply/divide unit with architectural HI/LO registers, in the EX stage directly downstream of the register file read ports.
- Takes rs/rt operands forwarded from the register-file read path, runs multi-cycle MULT/MULTU/DIV/DIVU, and serves MTHI/MTLO writes and MFHI/MFLO reads.
- Exposes busy so hazard logic can stall dependent MD instructions in decode.

---
 rtl/mdu_hilo.sv | 103 ++++++++++
 tb/tb_mdu_hilo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at issue, held in pending registers, and committed atomically when the busy window ends.
module mdu_hilo #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [63:0]   pend, pend_nx, res, smul, umul;
   logic          pend_wr, pend_wr_nx;
   logic [31:0]   hi_nx, lo_nx;
   logic [31:0]   abs_a, abs_b, sdvsr, udvsr, uq, ur, sq, sr, dq, dr;
   logic          is_md, is_mul, div_zero;

   // Divisors are forced to 1 on divide-by-zero so the datapath never sees /0; the commit is suppressed anyway.
   always_comb begin
      smul     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      umul     = {32'd0, A} * {32'd0, B};
      abs_a    = A[31] ? -A : A;
      abs_b    = B[31] ? -B : B;
      sdvsr    = (B == 32'd0) ? 32'd1 : abs_b;
      udvsr    = (B == 32'd0) ? 32'd1 : B;
      uq       = abs_a / sdvsr;
      ur       = abs_a % sdvsr;
      sq       = (A[31] ^ B[31]) ? -uq : uq;
      sr       = A[31] ? -ur : ur;
      dq       = A / udvsr;
      dr       = A % udvsr;
      res      = (op == OP_MULT)  ? smul :
                 (op == OP_MULTU) ? umul :
                 (op == OP_DIV)   ? {sr, sq} : {dr, dq};
      is_md    = (op >= OP_MULT) && (op <= OP_DIVU);
      is_mul   = (op == OP_MULT) || (op == OP_MULTU);
      div_zero = (B == 32'd0) && !is_mul;
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      pend_nx    = pend;
      pend_wr_nx = pend_wr;
      hi_nx      = HI;
      lo_nx      = LO;
      if (state == IDLE) begin
         if (start && is_md) begin
            state_nx   = RUN;
            cnt_nx     = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            pend_nx    = res;
            pend_wr_nx = !div_zero;
         end
         hi_nx = (start && op == OP_MTHI) ? A : HI;
         lo_nx = (start && op == OP_MTLO) ? A : LO;
      end else begin
         cnt_nx = cnt - 1'b1;
         if (cnt == CW'(1)) begin
            state_nx = IDLE;
            hi_nx    = pend_wr ? pend[63:32] : HI;
            lo_nx    = pend_wr ? pend[31:0]  : LO;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         pend    <= '0;
         pend_wr <= 1'b0;
         HI      <= '0;
         LO      <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         pend    <= pend_nx;
         pend_wr <= pend_wr_nx;
         HI      <= hi_nx;
         LO      <= lo_nx;
      end
   end

   assign busy = (state == RUN);
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed tests for mdu_hilo with hand-computed HI/LO/busy expectations.
module tb_mdu_hilo;
   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi, lo;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      step();
      start = 1'b0; op = 3'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; op = 3'd5; a = 32'hFFFF_FFFF; b = 32'd0;
      step(); step();
      start = 1'b0; op = 3'd0;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++;
         $display("FAIL reset: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", busy, hi, lo);
      end
      reset = 1'b0;
   endtask

   task automatic test_mult();
      logic [2:0]  ops[2] = '{3'd1, 3'd2};
      logic [31:0] eh[2]  = '{32'hFFFF_FFFF, 32'h0000_0002};
      logic [31:0] el[2]  = '{32'hFFFF_FFFA, 32'hFFFF_FFFA};
      logic [31:0] ph = 32'd0, pl = 32'd0;
      for (int t = 0; t < 2; t++) begin
         issue(ops[t], 32'hFFFF_FFFE, 32'd3);
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b1 || hi !== ph || lo !== pl) begin
               errors++;
               $display("FAIL mult%0d run cyc%0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h", t, i, busy, hi, lo, ph, pl);
            end
            step();
         end
         checks++;
         if (busy !== 1'b0 || hi !== eh[t] || lo !== el[t]) begin
            errors++;
            $display("FAIL mult%0d result: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h", t, busy, hi, lo, eh[t], el[t]);
         end
         ph = eh[t]; pl = el[t];
      end
   endtask

   task automatic test_div();
      logic [2:0]  ops[2] = '{3'd3, 3'd4};
      logic [31:0] xa[2]  = '{32'hFFFF_FFF9, 32'd7};
      logic [31:0] eh[2]  = '{32'hFFFF_FFFF, 32'd1};
      logic [31:0] el[2]  = '{32'hFFFF_FFFD, 32'd3};
      logic [31:0] ph = 32'h0000_0002, pl = 32'hFFFF_FFFA;
      for (int t = 0; t < 2; t++) begin
         issue(ops[t], xa[t], 32'd2);
         for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b1 || hi !== ph || lo !== pl) begin
               errors++;
               $display("FAIL div%0d run cyc%0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h", t, i, busy, hi, lo, ph, pl);
            end
            step();
         end
         checks++;
         if (busy !== 1'b0 || hi !== eh[t] || lo !== el[t]) begin
            errors++;
            $display("FAIL div%0d result: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h", t, busy, hi, lo, eh[t], el[t]);
         end
         ph = eh[t]; pl = el[t];
      end
   endtask

   task automatic test_divzero_overflow();
      logic [31:0] xa[2] = '{32'd5, 32'h8000_0000};
      logic [31:0] xb[2] = '{32'd0, 32'hFFFF_FFFF};
      logic [31:0] eh[2] = '{32'h0000_1234, 32'd0};
      logic [31:0] el[2] = '{32'h0000_5678, 32'h8000_0000};
      logic [31:0] ph = 32'h0000_1234, pl = 32'h0000_5678;
      issue(3'd5, 32'h0000_1234, 32'd0);
      checks++;
      if (busy !== 1'b0 || hi !== 32'h0000_1234 || lo !== 32'd3) begin
         errors++;
         $display("FAIL mthi: busy=%b hi=%h lo=%h, want busy=0 hi=00001234 lo=00000003", busy, hi, lo);
      end
      issue(3'd6, 32'h0000_5678, 32'd0);
      checks++;
      if (busy !== 1'b0 || hi !== 32'h0000_1234 || lo !== 32'h0000_5678) begin
         errors++;
         $display("FAIL mtlo: busy=%b hi=%h lo=%h, want busy=0 hi=00001234 lo=00005678", busy, hi, lo);
      end
      for (int t = 0; t < 2; t++) begin
         issue(3'd3, xa[t], xb[t]);
         for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b1 || hi !== ph || lo !== pl) begin
               errors++;
               $display("FAIL divedge%0d run cyc%0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h", t, i, busy, hi, lo, ph, pl);
            end
            step();
         end
         checks++;
         if (busy !== 1'b0 || hi !== eh[t] || lo !== el[t]) begin
            errors++;
            $display("FAIL divedge%0d result: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h", t, busy, hi, lo, eh[t], el[t]);
         end
         ph = eh[t]; pl = el[t];
      end
   endtask

   task automatic test_busy_ignore();
      issue(3'd1, 32'd2, 32'd3);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL busyign run cyc%0d: busy=%b hi=%h lo=%h, want busy=1 hi=0 lo=80000000", i, busy, hi, lo);
         end
         if (i == 1) begin
            start = 1'b1; op = 3'd6; a = 32'h0000_DEAD;
         end
         step();
         start = 1'b0; op = 3'd0;
      end
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
         errors++;
         $display("FAIL busyign result: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=6", busy, hi, lo);
      end
   endtask

   task automatic test_none();
      issue(3'd0, 32'h1111_1111, 32'd3);
      issue(3'd7, 32'h2222_2222, 32'd3);
      step();
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
         errors++;
         $display("FAIL none_op: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=6", busy, hi, lo);
      end
   endtask

   task automatic test_reset_mid();
      issue(3'd4, 32'd100, 32'd7);
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd6) begin
            errors++;
            $display("FAIL rstmid run cyc%0d: busy=%b hi=%h lo=%h, want busy=1 hi=0 lo=6", i, busy, hi, lo);
         end
         if (i < 4) step();
      end
      reset = 1'b1; start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
      step();
      reset = 1'b0; start = 1'b0; op = 3'd0;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++;
         $display("FAIL rstmid after: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", busy, hi, lo);
      end
      for (int i = 0; i < 12; i++) step();
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++;
         $display("FAIL rstmid late: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", busy, hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      issue(3'd1, 32'd4, 32'd5);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL b2b mult cyc%0d: busy=%b hi=%h lo=%h, want busy=1 hi=0 lo=0", i, busy, hi, lo);
         end
         step();
      end
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd20) begin
         errors++;
         $display("FAIL b2b mult result: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=14", busy, hi, lo);
      end
      issue(3'd4, 32'd9, 32'd4);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd20) begin
            errors++;
            $display("FAIL b2b divu cyc%0d: busy=%b hi=%h lo=%h, want busy=1 hi=0 lo=14", i, busy, hi, lo);
         end
         step();
      end
      checks++;
      if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd2) begin
         errors++;
         $display("FAIL b2b divu result: busy=%b hi=%h lo=%h, want busy=0 hi=1 lo=2", busy, hi, lo);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
      test_reset();
      test_mult();
      test_div();
      test_divzero_overflow();
      test_busy_ignore();
      test_none();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
